sub86_mem: RTL and testbench
============================

Name: sub86_mem

Overview:
- Memory responder for the sub86 core: a unified byte-addressed RAM.
- Serves the core's 16-bit instruction fetch port (IA/ID) and its 32-bit data port (A/D/Q/WEN/BEN).
- Includes a boot loader. After reset it streams a program image into RAM over a valid/ready byte interface, then releases the core from reset.
- Sits between the core and the board-level program source (UART/host bridge).

Parameters:
- AW, 12, RAM address width in bytes; size = 2^AW bytes. All addresses use their low AW bits (modulo wrap).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- CPU_RSTN  out  1  reset to core, active-low, registered.
- IA  in  32  instruction fetch byte address.
- ID  out  16  instruction halfword, {mem[IA], mem[IA+1]}, combinational.
- A  in  32  data byte address.
- D  out  32  read data, {mem[A+3], mem[A+2], mem[A+1], mem[A]}, combinational.
- Q  in  32  write data.
- WEN  in  1  write enable, active-low.
- BEN  in  2  write size: 00 and 10 = byte, 11 = 16-bit, 01 = 32-bit.
- LD_VALID  in  1  loader byte valid.
- LD_DATA  in  8  loader byte.
- LD_LAST  in  1  marks final byte of image; qualified by LD_VALID.
- LD_READY  out  1  loader can accept a byte, registered.
- LD_DONE  out  1  image loaded, core running, registered.

Behaviour:
- States: LOAD, RUN. State register and counter are reset; RAM contents are never reset.
- Reset (RSTN=0 at an edge):
  - state<=LOAD, load counter<=0.
  - CPU_RSTN<=0, LD_READY<=0, LD_DONE<=0.
  - RAM contents are retained.
- LOAD:
  - LD_READY is 1 from the first edge after RSTN is sampled high.
  - Accept occurs when LD_VALID & LD_READY at an edge: mem[cnt]<=LD_DATA, cnt<=cnt+1.
  - LD_VALID with LD_READY=0 is ignored. The source must hold the byte until accepted.
  - Load ends on an accept with LD_LAST=1, or on an accept at cnt=2^AW-1 (full wrap-guard).
  - At that edge: state<=RUN, LD_READY<=0, LD_DONE<=1, CPU_RSTN<=1.
  - Core writes (WEN) are ignored in LOAD.
- RUN:
  - LD_READY=0; LD_VALID is ignored.
  - CPU_RSTN and LD_DONE stay 1 until the next RSTN assertion.
- Data write: at an edge in RUN with WEN=0, writes are little-endian starting at A:
  - byte size: mem[A]<=Q[7:0].
  - 16-bit size: additionally mem[A+1]<=Q[15:8].
  - 32-bit size: additionally mem[A+2]<=Q[23:16], mem[A+3]<=Q[31:24].
  - Address increments wrap modulo 2^AW.
  - Unaligned accesses are legal.
- Reads: D and ID are purely combinational from the current RAM contents. There are no wait states, since the core has no stall input.
  - A read in the same cycle as a write to the same bytes returns the old data.
  - The new data is visible the cycle after the write edge.
  - IA+1, A+1..A+3 wrap modulo 2^AW.
  - ID and D are valid in every state, including LOAD. Values during LOAD are don't-care to the core.
- Reset mid-LOAD or mid-RUN: the core is re-held in reset and a fresh load starts at address 0.
  - Previously loaded bytes beyond the new image remain.
- Simultaneous final accept and RSTN=0: reset wins.

Test Plan:
1. Load, byte interface: after reset, stream bytes 90,BB,34,12 with LD_LAST on the 4th byte.
   - LD_READY rises 1 cycle after RSTN release.
   - CPU_RSTN and LD_DONE rise at the edge accepting 0x12.
   - In RUN, IA=0 gives ID=0x90BB; IA=2 gives ID=0x3412.
2. Backpressure and valid gaps: toggle LD_VALID randomly during LOAD → bytes land at consecutive addresses with none dropped or duplicated. LD_VALID in RUN does not change RAM.
3. Write sizes: in RUN, A=0x10, Q=0xAABBCCDD, WEN=0.
   - BEN=00: D@0x10=0x000000DD (pre-zeroed RAM).
   - BEN=11: D=0x0000CCDD.
   - BEN=01: D=0xAABBCCDD.
   - BEN=10 behaves as byte.
   - D is unchanged during the write cycle and updated the next cycle.
4. Wrap: AW=12, 32-bit write at A=0xFFE → bytes land at 0xFFE, 0xFFF, 0x000, 0x001. ID at IA=0xFFF = {mem[0xFFF], mem[0x000]}.
5. Full image: stream 4096 bytes without LD_LAST → load ends on the 4096th accept and CPU_RSTN rises. A further LD_VALID is not accepted.
6. Reset mid-RUN: assert RSTN low 1 cycle → CPU_RSTN=0, LD_DONE=0, old contents are readable via D. A 1-byte reload with LD_LAST changes only address 0.

Source files
------------

// File: rtl/sub86_mem_if.sv
// sub86_mem_if: bus bundle between the sub86 core / program source and the
// memory responder.
//   IA/ID              : instruction fetch address in, halfword out
//   A/D/Q/WEN/BEN      : data port (address, read data, write data, strobes)
//   LD_VALID/LD_DATA/LD_LAST/LD_READY/LD_DONE : boot loader byte stream
// master = core + loader source side, slave = memory responder.
interface sub86_mem_if;
    logic [31:0] IA;
    logic [15:0] ID;
    logic [31:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        WEN;
    logic [1:0]  BEN;
    logic        LD_VALID;
    logic [7:0]  LD_DATA;
    logic        LD_LAST;
    logic        LD_READY;
    logic        LD_DONE;

    modport master (
        output IA, A, Q, WEN, BEN, LD_VALID, LD_DATA, LD_LAST,
        input  ID, D, LD_READY, LD_DONE
    );

    modport slave (
        input  IA, A, Q, WEN, BEN, LD_VALID, LD_DATA, LD_LAST,
        output ID, D, LD_READY, LD_DONE
    );
endinterface

// File: rtl/sub86_mem.sv
// sub86_mem: unified byte-addressed RAM for the sub86 core with boot loader.
//   CLK      : clock, all state on rising edge
//   RSTN     : synchronous active-low reset (RAM contents retained)
//   CPU_RSTN : registered active-low reset to the core, released after load
//   bus      : sub86_mem_if slave (fetch port, data port, loader stream)
// After reset the loader streams bytes into RAM from address 0; the last
// byte (LD_LAST, or the byte at the top address) switches to RUN and
// releases the core. Reads are combinational, writes little-endian.
module sub86_mem #(
    parameter int AW = 12
) (
    input  logic      CLK,
    input  logic      RSTN,
    output logic      CPU_RSTN,
    sub86_mem_if.slave bus
);
    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [7:0]    mem [0:(2**AW)-1];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          cpu_rstn_q, cpu_rstn_d;

    logic          ld_acc;
    logic          cpu_we;
    logic          wr_half;
    logic          wr_word;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [AW-1:0] i0, i1;

    // Only the low AW address bits select RAM; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.IA[31:AW], bus.A[31:AW]};

    assign a0 = bus.A[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign i0 = bus.IA[AW-1:0];
    assign i1 = i0 + AW'(1);

    assign bus.ID = {mem[i0], mem[i1]};
    assign bus.D  = {mem[a3], mem[a2], mem[a1], mem[a0]};

    assign bus.LD_READY = ready_q;
    assign bus.LD_DONE  = done_q;
    assign CPU_RSTN     = cpu_rstn_q;

    // BEN: 01 = word, 11 = halfword, 00/10 = byte
    assign wr_half = bus.BEN[0];
    assign wr_word = (bus.BEN == 2'b01);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        done_d     = done_q;
        cpu_rstn_d = cpu_rstn_q;
        ld_acc     = (state_q == LOAD) && ready_q && bus.LD_VALID;
        cpu_we     = (state_q == RUN) && !bus.WEN;
        if (state_q == LOAD) begin
            ready_d = 1'b1;
            if (ld_acc) begin
                cnt_d = cnt_q + AW'(1);
                // Top-address accept ends the load so the counter never wraps
                // over already loaded bytes.
                if (bus.LD_LAST || (cnt_q == '1)) begin
                    state_d    = RUN;
                    ready_d    = 1'b0;
                    done_d     = 1'b1;
                    cpu_rstn_d = 1'b1;
                end
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            cpu_rstn_q <= cpu_rstn_d;
        end
    end

    // RAM is not reset; a reset edge suppresses any write so reset wins
    // over a coincident final loader accept.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            if (ld_acc) begin
                mem[cnt_q] <= bus.LD_DATA;
            end else if (cpu_we) begin
                mem[a0] <= bus.Q[7:0];
                if (wr_half) begin
                    mem[a1] <= bus.Q[15:8];
                end
                if (wr_word) begin
                    mem[a2] <= bus.Q[23:16];
                    mem[a3] <= bus.Q[31:24];
                end
            end
        end
    end
endmodule

// File: tb/tb_sub86_mem.sv
module tb_sub86_mem;
    localparam int unsigned SZ = 4096;

    logic CLK;
    logic RSTN;
    logic CPU_RSTN;

    sub86_mem_if bus();

    sub86_mem #(.AW(12)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .CPU_RSTN (CPU_RSTN),
        .bus      (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    // reference model
    logic [7:0]  mdl [SZ];
    logic [7:0]  img [SZ];
    bit          m_load = 1'b1;
    int unsigned m_cnt = 0;
    bit          m_ready = 1'b0;
    bit          m_done = 1'b0;
    bit          m_cpurstn = 1'b0;
    bit          data_known = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned wrap(input logic [31:0] a, input int unsigned k);
        return (int'(a[11:0]) + k) % SZ;
    endfunction

    always @(posedge CLK) begin
        if (!RSTN) begin
            m_load = 1'b1; m_cnt = 0; m_ready = 1'b0; m_done = 1'b0; m_cpurstn = 1'b0;
        end else if (m_load) begin
            if (bus.LD_VALID && m_ready) begin
                mdl[m_cnt] = bus.LD_DATA;
                if (bus.LD_LAST || m_cnt == SZ - 1) begin
                    m_load = 1'b0; m_ready = 1'b0; m_done = 1'b1; m_cpurstn = 1'b1;
                end
                m_cnt = (m_cnt + 1) % SZ;
            end else begin
                m_ready = 1'b1;
            end
        end else if (!bus.WEN) begin
            int unsigned n;
            n = (bus.BEN == 2'b01) ? 4 : (bus.BEN == 2'b11) ? 2 : 1;
            for (int unsigned k = 0; k < n; k++)
                mdl[wrap(bus.A, k)] = bus.Q[8*k +: 8];
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cpu_rstn", {31'd0, CPU_RSTN}, {31'd0, m_cpurstn});
            check("ld_ready", {31'd0, bus.LD_READY}, {31'd0, m_ready});
            check("ld_done", {31'd0, bus.LD_DONE}, {31'd0, m_done});
            if (data_known) begin
                check("ID", {16'd0, bus.ID}, {16'd0, mdl[wrap(bus.IA, 0)], mdl[wrap(bus.IA, 1)]});
                check("D", bus.D, {mdl[wrap(bus.A, 3)], mdl[wrap(bus.A, 2)],
                                   mdl[wrap(bus.A, 1)], mdl[wrap(bus.A, 0)]});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int unsigned len, input bit use_last);
        int unsigned cyc = 0;
        while (m_load && cyc < 30000) begin
            bus.LD_VALID = ($urandom_range(3) != 0);
            bus.LD_DATA  = img[m_cnt];
            bus.LD_LAST  = use_last && (m_cnt == len - 1);
            step();
            cyc++;
        end
        bus.LD_VALID = 1'b0;
        bus.LD_LAST  = 1'b0;
        check("load_end_cpu_rstn", {31'd0, CPU_RSTN}, 32'd1);
    endtask

    task automatic reset_pulse(input int unsigned n);
        RSTN = 1'b0;
        repeat (n) step();
        RSTN = 1'b1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] q, input logic [1:0] ben);
        bus.A = a; bus.Q = q; bus.BEN = ben; bus.WEN = 1'b0;
        step();
        bus.WEN = 1'b1;
    endtask

    initial begin
        logic [1:0] bens [4];
        logic [31:0] bexp [4];
        bens[0] = 2'b00; bexp[0] = 32'h000000DD;
        bens[1] = 2'b11; bexp[1] = 32'h0000CCDD;
        bens[2] = 2'b01; bexp[2] = 32'hAABBCCDD;
        bens[3] = 2'b10; bexp[3] = 32'h000000DD;

        RSTN = 1'b0;
        bus.IA = '0; bus.A = '0; bus.Q = '0; bus.WEN = 1'b1; bus.BEN = 2'b00;
        bus.LD_VALID = 1'b0; bus.LD_DATA = '0; bus.LD_LAST = 1'b0;
        step(); step();
        chk_en = 1'b1;
        check("rst_cpu_rstn", {31'd0, CPU_RSTN}, 32'd0);
        check("rst_ld_ready", {31'd0, bus.LD_READY}, 32'd0);
        check("rst_ld_done", {31'd0, bus.LD_DONE}, 32'd0);

        // full image, no LD_LAST: ends on the 4096th accept
        RSTN = 1'b1;
        step();
        check("ready_after_release", {31'd0, bus.LD_READY}, 32'd1);
        for (int i = 0; i < int'(SZ); i++) img[i] = 8'($urandom);
        load(SZ, 1'b0);
        data_known = 1'b1;
        check("full_done", {31'd0, bus.LD_DONE}, 32'd1);
        bus.LD_VALID = 1'b1; bus.LD_DATA = 8'hEE;
        repeat (4) step();
        check("run_ready_low", {31'd0, bus.LD_READY}, 32'd0);
        bus.A = 32'd0;
        check("run_valid_ignored", bus.D, {img[3], img[2], img[1], img[0]});
        bus.LD_VALID = 1'b0;

        // reset coinciding with the final accept: reset wins
        reset_pulse(1);
        step();
        bus.LD_VALID = 1'b1; bus.LD_DATA = 8'h77; bus.LD_LAST = 1'b1; RSTN = 1'b0;
        step();
        RSTN = 1'b1; bus.LD_VALID = 1'b0; bus.LD_LAST = 1'b0;
        check("reset_wins_cpu_rstn", {31'd0, CPU_RSTN}, 32'd0);
        check("reset_wins_mem0", {24'd0, bus.D[7:0]}, {24'd0, img[0]});

        // 4-byte image with LD_LAST
        step();
        img[0] = 8'h90; img[1] = 8'hBB; img[2] = 8'h34; img[3] = 8'h12;
        load(4, 1'b1);
        bus.IA = 32'd0; #1;
        check("ID_at_0", {16'd0, bus.ID}, 32'h000090BB);
        bus.IA = 32'd2; #1;
        check("ID_at_2", {16'd0, bus.ID}, 32'h00003412);

        // write sizes at 0x10
        foreach (bens[i]) begin
            write(32'h10, 32'h0, 2'b01);
            bus.A = 32'h10; bus.Q = 32'hAABBCCDD; bus.BEN = bens[i]; bus.WEN = 1'b0;
            #1;
            check("D_old_during_write", bus.D, 32'h0);
            step();
            bus.WEN = 1'b1;
            #1;
            check("D_after_write", bus.D, bexp[i]);
        end

        // wrap-around write and fetch
        write(32'hFFE, 32'h11223344, 2'b01);
        bus.A = 32'hFFE; bus.IA = 32'hFFF; #1;
        check("wrap_D", bus.D, 32'h11223344);
        check("wrap_ID", {16'd0, bus.ID}, 32'h00003322);
        bus.A = 32'h0; #1;
        check("wrap_mem0", {16'd0, bus.D[15:0]}, 32'h00001122);

        // randomized RUN traffic
        repeat (400) begin
            bus.IA = $urandom;
            bus.A  = ($urandom_range(3) == 0) ? (32'hFFC + 32'($urandom_range(3))) : $urandom;
            bus.Q  = $urandom;
            bus.BEN = 2'($urandom);
            bus.WEN = ($urandom_range(1) == 0);
            bus.LD_VALID = ($urandom_range(1) == 0);
            bus.LD_DATA = 8'($urandom);
            step();
        end
        bus.WEN = 1'b1; bus.LD_VALID = 1'b0;

        // reset mid-RUN, then 1-byte reload
        reset_pulse(1);
        check("midrun_cpu_rstn", {31'd0, CPU_RSTN}, 32'd0);
        check("midrun_ld_done", {31'd0, bus.LD_DONE}, 32'd0);
        step();
        img[0] = 8'h5A;
        load(1, 1'b1);
        bus.A = 32'd0; #1;
        check("reload_byte0", {24'd0, bus.D[7:0]}, 32'h0000005A);
        repeat (20) begin
            bus.A = $urandom; bus.IA = $urandom;
            step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
